// File: rtl/spike_pkg.sv
// Shared definitions for the spiking network and the rate decoder:
// channel/counter/window defaults and the decoder state encoding.
package spike_pkg;

  localparam int unsigned NUM_CH_DEF = 4;
  localparam int unsigned CNT_W_DEF  = 4;
  localparam int unsigned WIN_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/spike_sat_counter.sv
// Per-channel saturating spike counter; sat_hit flags an increment attempt
// made while the counter already sits at its maximum.
module spike_sat_counter
  import spike_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat_hit
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sat_hit = inc && (cnt_q == CNT_MAX);
  assign cnt     = cnt_q;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat_hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Rate decoder: counts spikes per channel over a programmable window, then
// holds counts, winner, any_spike and sat until the consumer accepts them.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int WIN_W  = WIN_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       spike_in,
  input  logic                    enable,
  input  logic [WIN_W-1:0]        window_len,
  input  logic                    ready,
  output logic [NUM_CH*CNT_W-1:0] counts,
  output logic [1:0]              winner,
  output logic                    any_spike,
  output logic                    sat,
  output logic                    valid,
  output logic                    busy
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] len_q, len_d;
  logic [WIN_W-1:0] smp_q, smp_d;
  logic             sat_acc_q, sat_acc_d;
  logic [1:0]       winner_q, winner_d;
  logic             any_q, any_d;
  logic             sat_q, sat_d;

  logic              counting, launch, start, clr;
  logic [NUM_CH-1:0] inc, sat_hit;
  logic [CNT_W-1:0]  cnt     [NUM_CH];
  logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
  logic [1:0]        best_idx;
  logic [CNT_W-1:0]  best_val;

  assign counting = (state_q == ST_COUNT);
  assign launch   = enable && (window_len != '0);
  assign inc      = spike_in & {NUM_CH{counting}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    spike_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .inc     (inc[g]),
      .cnt     (cnt[g]),
      .sat_hit (sat_hit[g])
    );
    assign counts[g*CNT_W +: CNT_W] = cnt[g];
    // Post-edge count, so the winner registered on HOLD entry sees the last sample.
    assign cnt_nxt[g] = cnt[g] + CNT_W'(inc[g] & ~sat_hit[g]);
  end

  // Strict greater-than keeps ties on the lowest index; all-zero leaves index 0.
  always_comb begin
    best_idx = '0;
    best_val = cnt_nxt[0];
    for (int k = 1; k < NUM_CH; k++) begin
      if (cnt_nxt[k] > best_val) begin
        best_idx = 2'(k);
        best_val = cnt_nxt[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    smp_d     = smp_q;
    sat_acc_d = sat_acc_q;
    winner_d  = winner_q;
    any_d     = any_q;
    sat_d     = sat_q;
    start     = 1'b0;
    clr       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        start = launch;
      end
      ST_COUNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          smp_d   = '0;
          clr     = 1'b1;
        end else begin
          sat_acc_d = sat_acc_q | (|sat_hit);
          smp_d     = smp_q + 1'b1;
          if (smp_q == len_q - 1'b1) begin
            state_d  = ST_HOLD;
            smp_d    = '0;
            winner_d = best_idx;
            any_d    = (best_val != '0);
            sat_d    = sat_acc_q | (|sat_hit);
          end
        end
      end
      ST_HOLD: begin
        if (ready) begin
          if (launch) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Window start: the launching cycle itself is not sampled.
    if (start) begin
      state_d   = ST_COUNT;
      len_d     = window_len;
      smp_d     = '0;
      sat_acc_d = 1'b0;
      winner_d  = '0;
      any_d     = 1'b0;
      sat_d     = 1'b0;
      clr       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      smp_q     <= '0;
      sat_acc_q <= 1'b0;
      winner_q  <= '0;
      any_q     <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      smp_q     <= smp_d;
      sat_acc_q <= sat_acc_d;
      winner_q  <= winner_d;
      any_q     <= any_d;
      sat_q     <= sat_d;
    end
  end

  assign winner    = winner_q;
  assign any_spike = any_q;
  assign sat       = sat_q;
  assign valid     = (state_q == ST_HOLD);
  assign busy      = counting;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: expected window results are queued
// as spikes are driven and compared when the decoder presents a result.
module tb_spike_rate_decoder;

  logic        clk = 1'b0;
  logic        reset, enable, ready;
  logic [3:0]  spike_in;
  logic [7:0]  window_len;
  logic [15:0] counts;
  logic [1:0]  winner;
  logic        any_spike, sat, valid, busy;

  typedef struct packed {
    logic [15:0] counts;
    logic [1:0]  winner;
    logic        any;
    logic        sat;
  } result_t;

  result_t    sb[$];
  logic [3:0] stim[$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  spike_rate_decoder #(.NUM_CH(4), .CNT_W(4), .WIN_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .spike_in   (spike_in),
    .enable     (enable),
    .window_len (window_len),
    .ready      (ready),
    .counts     (counts),
    .winner     (winner),
    .any_spike  (any_spike),
    .sat        (sat),
    .valid      (valid),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result for the first len entries of stim.
  function automatic result_t model(input int len);
    result_t r;
    int c[4];
    int best;
    r = '0;
    c = '{default: 0};
    for (int i = 0; i < len; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (stim[i][k]) begin
          if (c[k] == 15) r.sat = 1'b1;
          else c[k]++;
        end
      end
    end
    best = 0;
    for (int k = 1; k < 4; k++) if (c[k] > c[best]) best = k;
    r.winner = 2'(best);
    r.any    = (c[best] != 0);
    for (int k = 0; k < 4; k++) r.counts[k*4 +: 4] = 4'(c[k]);
    return r;
  endfunction

  task automatic start_window(input logic [7:0] len);
    enable     = 1'b1;
    window_len = len;
    spike_in   = 4'hF;
    tick();
  endtask

  // Drives one window from stim (state must already be COUNT), checks the
  // result, stalls in HOLD, then hands off with the given enable/window_len.
  task automatic count_and_check(input string name, input int len, input int stall,
                                 input logic next_en, input logic [7:0] next_len);
    result_t exp, got;
    sb.push_back(model(len));
    ready = 1'b0;
    for (int i = 0; i < len; i++) begin
      checks++;
      if (busy !== 1'b1 || valid !== 1'b0) begin
        errors++;
        $display("FAIL %s_counting cycle %0d busy=%b valid=%b expected busy=1 valid=0", name, i, busy, valid);
      end
      spike_in   = stim[i];
      window_len = 8'($urandom);
      tick();
    end
    exp = sb.pop_front();
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_latency valid=%b busy=%b expected valid=1 busy=0", name, valid, busy);
    end
    got = result_t'({counts, winner, any_spike, sat});
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s_result counts=%h winner=%0d any=%b sat=%b expected counts=%h winner=%0d any=%b sat=%b",
               name, got.counts, got.winner, got.any, got.sat, exp.counts, exp.winner, exp.any, exp.sat);
    end
    for (int s = 0; s < stall; s++) begin
      spike_in   = 4'($urandom);
      enable     = 1'($urandom);
      window_len = 8'($urandom);
      tick();
      got = result_t'({counts, winner, any_spike, sat});
      checks++;
      if (valid !== 1'b1 || got !== exp) begin
        errors++;
        $display("FAIL %s_hold stall %0d valid=%b counts=%h winner=%0d expected valid=1 counts=%h winner=%0d",
                 name, s, valid, got.counts, got.winner, exp.counts, exp.winner);
      end
    end
    ready      = 1'b1;
    enable     = next_en;
    window_len = next_len;
    spike_in   = 4'($urandom);
    tick();
    ready = 1'b0;
    checks++;
    if (busy !== next_en || valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_handshake busy=%b valid=%b expected busy=%b valid=0", name, busy, valid, next_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; ready = 1'b0; spike_in = 4'hF; window_len = 8'd0;
    tick();
    tick();
    checks++;
    if ({counts, winner, any_spike, sat, valid, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_values counts=%h winner=%0d any=%b sat=%b valid=%b busy=%b expected all 0",
               counts, winner, any_spike, sat, valid, busy);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_single_channel();
    stim = {};
    for (int i = 0; i < 5; i++) stim.push_back(4'b0001);
    start_window(8'd5);
    count_and_check("single", 5, 0, 1'b0, 8'd0);
  endtask

  task automatic test_saturation();
    stim = {};
    for (int i = 0; i < 20; i++) stim.push_back(4'b0100);
    start_window(8'd20);
    count_and_check("saturate", 20, 2, 1'b0, 8'd0);
  endtask

  task automatic test_tie();
    stim = {4'b1010, 4'b1010, 4'b1010, 4'b0000};
    start_window(8'd4);
    count_and_check("tie", 4, 0, 1'b0, 8'd0);
  endtask

  task automatic test_no_spikes();
    stim = {};
    for (int i = 0; i < 10; i++) stim.push_back(4'b0000);
    start_window(8'd10);
    count_and_check("silent", 10, 1, 1'b0, 8'd0);
  endtask

  task automatic test_zero_len();
    enable = 1'b1; window_len = 8'd0; spike_in = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (busy !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_len cycle %0d busy=%b valid=%b expected 0 0", i, busy, valid);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_abort();
    bit seen_valid = 1'b0;
    start_window(8'd8);
    for (int i = 0; i < 3; i++) begin
      spike_in = 4'b1111;
      if (i == 2) enable = 1'b0;
      tick();
    end
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || counts !== 16'h0000) begin
      errors++;
      $display("FAIL abort_state busy=%b valid=%b counts=%h expected 0 0 0000", busy, valid, counts);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_valid saw valid=1 expected none");
    end
    stim = {4'b0001, 4'b0001, 4'b0001};
    start_window(8'd3);
    count_and_check("after_abort", 3, 0, 1'b0, 8'd0);
  endtask

  task automatic test_back_to_back();
    stim = {};
    for (int i = 0; i < 6; i++) stim.push_back(4'($urandom));
    start_window(8'd6);
    count_and_check("stall_b2b", 6, 7, 1'b1, 8'd4);
    stim = {4'b1000, 4'b1000, 4'b0110, 4'b1000};
    count_and_check("b2b_second", 4, 0, 1'b0, 8'd0);
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      int len;
      len  = $urandom_range(1, 18);
      stim = {};
      for (int i = 0; i < len; i++) stim.push_back(4'($urandom));
      start_window(8'(len));
      count_and_check("random", len, $urandom_range(0, 3), 1'b0, 8'd0);
    end
  endtask

  task automatic test_reset_mid_window();
    bit seen_valid = 1'b0;
    start_window(8'd6);
    for (int i = 0; i < 3; i++) begin
      spike_in = 4'b1111;
      tick();
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({counts, winner, any_spike, sat, valid, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid counts=%h valid=%b busy=%b expected all 0", counts, valid, busy);
    end
    reset = 1'b1; enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (valid === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_valid saw valid=1 expected none");
    end
    // Reset while a result is held in HOLD.
    start_window(8'd2);
    ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      spike_in = 4'b0010;
      tick();
    end
    enable = 1'b0;
    reset  = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({counts, winner, any_spike, sat, valid, busy} !== 22'd0) begin
      errors++;
      $display("FAIL reset_hold counts=%h winner=%0d any=%b valid=%b expected all 0", counts, winner, any_spike, valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_saturation();
    test_tie();
    test_no_spikes();
    test_zero_len();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_mid_window();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spike_rate_decoder.md
SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 Parameter NUM_CH, default 4, number of spike input channels.
REQ-002 Parameter CNT_W, default 4, per-channel spike count width.
REQ-003 Parameter WIN_W, default 8, window-length field width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-low; all outputs take reset values on the first rising clk edge with reset=0.
REQ-006 spike_in  input  NUM_CH  one spike pulse per bit per cycle, sampled each clk (bit 0 = neuron 1 ... bit 3 = output neuron).
REQ-007 enable  input  1  1 = run counting windows; 0 = stop or abort.
REQ-008 window_len  input  WIN_W  window length in clk cycles; latched at window start.
REQ-009 ready  input  1  consumer accepts the current result.
REQ-010 counts  output  NUM_CH*CNT_W  per-channel spike counts, channel k at bits [k*CNT_W +: CNT_W].
REQ-011 winner  output  2  index of the channel with the highest count.
REQ-012 any_spike  output  1  1 if any count in the result is non-zero.
REQ-013 sat  output  1  1 if any channel count saturated during the window.
REQ-014 valid  output  1  result on counts/winner/any_spike/sat is valid.
REQ-015 busy  output  1  1 while in COUNT state.

Function
REQ-016 FSM states IDLE, COUNT, HOLD; reset state IDLE.
REQ-017 IDLE: enable=1 and window_len!=0 -> latch window_len, clear counters and sat, go to COUNT; window_len=0 -> stay IDLE, no result.
REQ-018 The IDLE->COUNT transition cycle is not sampled; the first sampled cycle is the first cycle in COUNT.
REQ-019 COUNT: each cycle, every counter whose spike_in bit is 1 increments by 1, saturating at 2^CNT_W-1.
REQ-020 An increment attempt on a counter already at maximum sets sat; sat stays set until the next window start.
REQ-021 COUNT samples exactly the latched window_len cycles, then enters HOLD; valid rises on the first HOLD cycle, i.e. window_len+1 cycles after the IDLE transition edge.
REQ-022 window_len changes during COUNT or HOLD have no effect on the current window.
REQ-023 enable=0 in COUNT -> abort: go IDLE next cycle, clear counters, no valid pulse.
REQ-024 HOLD: valid=1; counts, winner, any_spike and sat stay stable until valid&&ready.
REQ-025 On the valid&&ready cycle: enable=1 and window_len!=0 -> go COUNT with cleared counters (back-to-back window, handshake cycle not sampled); otherwise go IDLE.
REQ-026 enable=0 in HOLD does not drop the result; valid holds until ready.
REQ-027 spike_in is ignored in IDLE and HOLD.
REQ-028 winner is the index of the maximum count, with ties going to the lowest index; all counts zero -> winner=0, any_spike=0.
REQ-029 winner, any_spike and sat are registered and update on the HOLD entry edge together with valid.
REQ-030 busy=1 exactly while the state is COUNT.

Reset
REQ-031 Reset values: counts=0, winner=0, any_spike=0, sat=0, valid=0, busy=0, state=IDLE, window counter=0.
REQ-032 Reset asserted mid-window or in HOLD discards the result; no valid follows reset release until a new full window completes.

Structure
REQ-033 The state encoding, NUM_CH, CNT_W and WIN_W defaults shall live in a shared package (spike_pkg) used by the neuron network and the decoder.
REQ-034 The per-channel saturating counter shall be one sub-module, spike_sat_counter (inputs clr, inc; outputs cnt, sat_hit), instantiated NUM_CH times.
REQ-035 The winner comparison shall be combinational inside spike_rate_decoder, with a registered output.

Verification
REQ-036 window_len=5, spike_in=4'b0001 every cycle, ready=1 -> valid on cycle 6, counts ch0=5, others 0, winner=0, any_spike=1, sat=0.
REQ-037 window_len=20, ch2 spiking every cycle -> ch2=15, sat=1, winner=2.
REQ-038 window_len=4, ch1 and ch3 each spike 3 times -> winner=1 (tie goes to the lower index).
REQ-039 window_len=10, no spikes -> counts all 0, winner=0, any_spike=0, valid=1.
REQ-040 enable dropped on window cycle 3 of 8 -> no valid; next window counts start from 0.
REQ-041 ready=0 for 7 cycles in HOLD with spikes toggling -> outputs unchanged; with enable=1, a new window starts on the cycle after the handshake; reset asserted mid-window -> all outputs 0.
